// File: rtl/count_monitor.sv
// count_monitor: passive lock-and-check monitor for a +1-per-cycle counter bus
//   clk, rst (sync, active-high); count_in[WIDTH] sampled every edge
//   locked; err/stall/skip/wrap one-cycle pulses; err_count/wrap_count saturating stats
//   COUNT_MON_CAPTURE_EN adds err_exp/err_obs: sticky capture of the first error since reset
module count_monitor #(
  parameter int WIDTH    = 32,
  parameter int LOCK_CNT = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              err_pulse,
  output logic              stall_pulse,
  output logic              skip_pulse,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
`ifdef COUNT_MON_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]  err_exp,
  output logic [WIDTH-1:0]  err_obs
`endif
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  typedef enum logic {SYNC, LOCKED} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] prev, exp_val;
  logic prev_vld, good, err, stall, wrap;
  logic [RW-1:0] run, run_nx;
  always_comb begin
    exp_val  = prev + 1'b1;
    good     = prev_vld && (count_in == exp_val);
    err      = (state == LOCKED) && !good;
    stall    = err && (count_in == prev);
    wrap     = (state == LOCKED) && good && (&prev);
    run_nx   = (state == SYNC && good) ? run + 1'b1 : '0;
    state_nx = (state == SYNC) ? ((run_nx == RW'(LOCK_CNT)) ? LOCKED : SYNC)
                               : (good ? LOCKED : SYNC);
  end
  assign locked = (state == LOCKED);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      run         <= '0;
      prev        <= '0;
      prev_vld    <= 1'b0;
      err_pulse   <= 1'b0;
      stall_pulse <= 1'b0;
      skip_pulse  <= 1'b0;
      wrap_pulse  <= 1'b0;
      err_count   <= '0;
      wrap_count  <= '0;
    end else begin
      state       <= state_nx;
      run         <= run_nx;
      prev        <= count_in;
      prev_vld    <= 1'b1;
      err_pulse   <= err;
      stall_pulse <= stall;
      skip_pulse  <= err && !stall;
      wrap_pulse  <= wrap;
      if (err && !(&err_count)) err_count <= err_count + 1'b1;
      if (wrap && !(&wrap_count)) wrap_count <= wrap_count + 1'b1;
    end
  end
`ifdef COUNT_MON_CAPTURE_EN
  // err_count saturates and never returns to zero, so zero means "no error yet"
  always_ff @(posedge clk) begin
    if (rst) begin
      err_exp <= '0;
      err_obs <= '0;
    end else if (err && err_count == '0) begin
      err_exp <= exp_val;
      err_obs <= count_in;
    end
  end
`endif
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed self-checking bench for count_monitor
module tb_count_monitor;
  localparam int W = 10;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] count_in = '0;
  logic locked, err_pulse, stall_pulse, skip_pulse, wrap_pulse;
  logic [SW-1:0] err_count, wrap_count;
`ifdef COUNT_MON_CAPTURE_EN
  logic [W-1:0] err_exp, err_obs;
`endif
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int b;
  always #5 clk = ~clk;
  count_monitor #(.WIDTH(W), .LOCK_CNT(4), .STAT_W(SW)) dut (
    .clk(clk),
    .rst(rst),
    .count_in(count_in),
    .locked(locked),
    .err_pulse(err_pulse),
    .stall_pulse(stall_pulse),
    .skip_pulse(skip_pulse),
    .wrap_pulse(wrap_pulse),
    .err_count(err_count),
    .wrap_count(wrap_count)
`ifdef COUNT_MON_CAPTURE_EN
    ,
    .err_exp(err_exp),
    .err_obs(err_obs)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int v);
    @(negedge clk);
    count_in = W'(v);
    @(posedge clk);
    #1;
  endtask
  task automatic relock(input int v);
    rst = 1'b1;
    step(v - 4);
    rst = 1'b0;
    for (int i = v - 4; i <= v; i++) begin
      step(i);
      chk("relock_locked", 32'(locked), 32'(i == v));
    end
  endtask
  initial begin
    count_in = '0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_wrapcnt", 32'(wrap_count), 0);
    rst = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      step(i);
      chk("lock_locked", 32'(locked), 32'(i == 4));
      chk("lock_err", 32'(err_pulse), 0);
    end
    chk("lock_errcnt", 32'(err_count), 0);
    relock(99);
    step(100);
    chk("stall_pre", 32'(err_pulse), 0);
    step(100);
    chk("stall_stall", 32'(stall_pulse), 1);
    chk("stall_err", 32'(err_pulse), 1);
    chk("stall_skip", 32'(skip_pulse), 0);
    chk("stall_errcnt", 32'(err_count), 1);
    chk("stall_locked", 32'(locked), 0);
    for (int i = 101; i <= 104; i++) begin
      step(i);
      chk("stall_relock", 32'(locked), 32'(i == 104));
      chk("stall_once", 32'(stall_pulse), 0);
    end
    relock(199);
    step(200);
    step(202);
    chk("skip_skip", 32'(skip_pulse), 1);
    chk("skip_stall", 32'(stall_pulse), 0);
    chk("skip_err", 32'(err_pulse), 1);
    chk("skip_errcnt", 32'(err_count), 1);
    chk("skip_locked", 32'(locked), 0);
`ifdef COUNT_MON_CAPTURE_EN
    chk("cap_exp", 32'(err_exp), 201);
    chk("cap_obs", 32'(err_obs), 202);
`endif
    for (int i = 203; i <= 206; i++) step(i);
    chk("skip_relock", 32'(locked), 1);
    step(210);
    chk("skip2_skip", 32'(skip_pulse), 1);
    chk("skip2_errcnt", 32'(err_count), 2);
`ifdef COUNT_MON_CAPTURE_EN
    chk("cap_exp_sticky", 32'(err_exp), 201);
    chk("cap_obs_sticky", 32'(err_obs), 202);
`endif
    relock(12'h3FD);
    step(12'h3FE);
    chk("wrap_pre", 32'(wrap_pulse), 0);
    step(12'h3FF);
    chk("wrap_pre2", 32'(wrap_pulse), 0);
    step(0);
    chk("wrap_pulse", 32'(wrap_pulse), 1);
    chk("wrap_cnt", 32'(wrap_count), 1);
    chk("wrap_err", 32'(err_pulse), 0);
    chk("wrap_locked", 32'(locked), 1);
    step(1);
    chk("wrap_once", 32'(wrap_pulse), 0);
    chk("wrap_errcnt", 32'(err_count), 0);
    chk("wrap_locked2", 32'(locked), 1);
    relock(10);
    b = 10;
    for (int k = 1; k <= 5; k++) begin
      step(b + 2);
      chk("sat_err", 32'(err_pulse), 1);
      chk("sat_errcnt", 32'(err_count), 32'(k < 3 ? k : 3));
      if (err_pulse) pulses++;
      for (int j = 3; j <= 6; j++) step(b + j);
      chk("sat_relock", 32'(locked), 1);
      b += 6;
    end
    chk("sat_pulses", 32'(pulses), 5);
    chk("sat_final", 32'(err_count), 3);
    step(b + 1);
    chk("mid_locked", 32'(locked), 1);
    rst = 1'b1;
    step(b + 2);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_errcnt", 32'(err_count), 0);
    chk("mid_rst_err", 32'(err_pulse), 0);
    chk("mid_rst_skip", 32'(skip_pulse), 0);
    rst = 1'b0;
    step(0);
    chk("mid_jump_err", 32'(err_pulse), 0);
    chk("mid_jump_locked", 32'(locked), 0);
    for (int i = 1; i <= 4; i++) begin
      step(i);
      chk("mid_relock", 32'(locked), 32'(i == 4));
    end
    chk("mid_errcnt", 32'(err_count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
